cluster_collector: RTL and testbench

//  Downstream of the 1536-pad priority encoder. Each clock it takes one candidate {cnt, adr}, one per phase
//  of the 8-phase frame (one bunch crossing at 8x clock). It discards empty or duplicate candidates and

---
 rtl/cluster_collector_pkg.sv | 25 ++
 rtl/cluster_collector_if.sv | 30 +++
 rtl/cluster_collector_frame_phase_counter.sv | 32 +++
 rtl/cluster_collector.sv | 100 ++++++++++
 tb/tb_cluster_collector.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_collector_pkg.sv
// Shared definitions for the cluster collector: widths, the "no hit" address,
// the {cnt, adr} cluster word and the candidate address qualifier.
package cluster_collector_pkg;

   localparam int unsigned MXADRBITS  = 11;
   localparam int unsigned MXCNTBITS  = 3;
   localparam int unsigned MXPADS     = 1536;
   localparam int unsigned CLWORDBITS = MXCNTBITS + MXADRBITS;
   localparam int unsigned PHASEBITS  = 3;

   localparam logic [MXADRBITS-1:0] ADR_NONE = 11'h7FE;

   typedef struct packed {
      logic [MXCNTBITS-1:0] cnt;
      logic [MXADRBITS-1:0] adr;
   } cluster_t;

   localparam cluster_t CLUSTER_NONE = '{cnt: 3'd0, adr: ADR_NONE};

   // Address carries a real pad hit: not the empty marker and inside the pad range.
   function automatic logic cluster_valid(input logic [MXADRBITS-1:0] adr);
      return (adr != ADR_NONE) && (adr < MXADRBITS'(MXPADS));
   endfunction

endpackage

// File: rtl/cluster_collector_if.sv
// Encoder-to-collector-to-packer bus.
//  adr_in/cnt_in   : one encoder candidate per clock
//  clusters        : MXCLUSTERS packed {cnt, adr} slots, slot 0 in the low bits
//  n_clusters      : valid slot count
//  overflow        : more valid candidates than slots in the frame
//  frame_strobe    : one-cycle pulse when the frame outputs update
// master drives candidates and observes results; slave is the collector.
interface cluster_collector_if #(
   parameter int unsigned MXCLUSTERS = 8
);
   import cluster_collector_pkg::*;

   logic [MXADRBITS-1:0]             adr_in;
   logic [MXCNTBITS-1:0]             cnt_in;
   logic [MXCLUSTERS*CLWORDBITS-1:0] clusters;
   logic [3:0]                       n_clusters;
   logic                             overflow;
   logic                             frame_strobe;

   modport master (
      output adr_in, cnt_in,
      input  clusters, n_clusters, overflow, frame_strobe
   );

   modport slave (
      input  adr_in, cnt_in,
      output clusters, n_clusters, overflow, frame_strobe
   );

endinterface

// File: rtl/cluster_collector_frame_phase_counter.sv
// 8-phase frame counter shared by the encoder, collector and packer.
//  clock, global_reset : clock and synchronous active-high reset (phase -> 0)
//  frame_first_c       : current phase is frame slot 0 (phase == PHASE_OFFSET)
//  frame_last_c        : current phase is frame slot 7
module frame_phase_counter
   import cluster_collector_pkg::*;
#(
   parameter logic [2:0] PHASE_OFFSET = 3'd0
) (
   input  logic clock,
   input  logic global_reset,
   output logic frame_first_c,
   output logic frame_last_c
);

   logic [PHASEBITS-1:0] phase;
   logic [PHASEBITS-1:0] fph_c;

   // Free-running phase, wraps 7 -> 0.
   always_ff @(posedge clock) begin
      if (global_reset) phase <= '0;
      else              phase <= phase + PHASEBITS'(1);
   end

   // Frame slot index relative to the encoder-aligned offset.
   always_comb begin
      fph_c         = phase - PHASE_OFFSET;
      frame_first_c = (fph_c == PHASEBITS'(0));
      frame_last_c  = (fph_c == PHASEBITS'(7));
   end

endmodule

// File: rtl/cluster_collector.sv
// Cluster collector: compacts one encoder candidate per clock into an ordered
// list of MXCLUSTERS slots per 8-phase frame, dropping empty, out-of-range and
// repeated candidates, and publishes the list once per frame.
//  clock, global_reset : clock and synchronous active-high reset
//  bus (slave)         : adr_in/cnt_in in; clusters/n_clusters/overflow/frame_strobe out
module cluster_collector
   import cluster_collector_pkg::*;
#(
   parameter int unsigned MXCLUSTERS   = 8,
   parameter logic [2:0]  PHASE_OFFSET = 3'd0
) (
   input  logic               clock,
   input  logic               global_reset,
   cluster_collector_if.slave bus
);

   localparam int unsigned FILLBITS = 4;
   localparam int unsigned OUTBITS  = MXCLUSTERS * CLWORDBITS;
   localparam logic [OUTBITS-1:0] CLUSTERS_NONE = {MXCLUSTERS{CLUSTER_NONE}};

   logic                 frame_first_c;
   logic                 frame_last_c;

   cluster_t             cand_r;
   cluster_t             slots     [MXCLUSTERS];
   cluster_t             slots_nxt [MXCLUSTERS];
   logic [FILLBITS-1:0]  fill;
   logic [FILLBITS-1:0]  fill_base;
   logic [FILLBITS-1:0]  fill_nxt;
   logic                 ovf_acc;
   logic                 ovf_base;
   logic                 ovf_nxt;
   logic [MXADRBITS-1:0] last_adr;
   logic [MXADRBITS-1:0] last_base;
   logic [MXADRBITS-1:0] last_nxt;
   logic                 frame_open;
   logic                 cand_ok;
   logic                 accept;
   logic [OUTBITS-1:0]   clusters_nxt;

   frame_phase_counter #(
      .PHASE_OFFSET (PHASE_OFFSET)
   ) u_phase (
      .clock         (clock),
      .global_reset  (global_reset),
      .frame_first_c (frame_first_c),
      .frame_last_c  (frame_last_c)
   );

   // Candidate evaluation; frame-start clears accumulators ahead of the
   // decision so the slot-0 candidate is accepted in the same cycle.
   always_comb begin
      fill_base    = frame_first_c ? '0       : fill;
      ovf_base     = frame_first_c ? 1'b0     : ovf_acc;
      last_base    = frame_first_c ? ADR_NONE : last_adr;
      cand_ok      = cluster_valid(cand_r.adr) && (cand_r.adr != last_base);
      accept       = cand_ok && (fill_base < FILLBITS'(MXCLUSTERS));
      fill_nxt     = fill_base + FILLBITS'(accept);
      ovf_nxt      = ovf_base | (cand_ok & ~accept);
      last_nxt     = accept ? cand_r.adr : last_base;
      clusters_nxt = '0;
      for (int unsigned k = 0; k < MXCLUSTERS; k++) begin
         slots_nxt[k] = frame_first_c ? CLUSTER_NONE : slots[k];
         if (accept && (fill_base == FILLBITS'(k))) slots_nxt[k] = cand_r;
         clusters_nxt[k*CLWORDBITS +: CLWORDBITS] = slots_nxt[k];
      end
   end

   // Input register, accumulators and once-per-frame output register.
   // frame_open suppresses the strobe for a frame whose slot 0 preceded reset.
   always_ff @(posedge clock) begin
      if (global_reset) begin
         cand_r           <= CLUSTER_NONE;
         fill             <= '0;
         ovf_acc          <= 1'b0;
         last_adr         <= ADR_NONE;
         frame_open       <= 1'b0;
         for (int unsigned k = 0; k < MXCLUSTERS; k++) slots[k] <= CLUSTER_NONE;
         bus.clusters     <= CLUSTERS_NONE;
         bus.n_clusters   <= '0;
         bus.overflow     <= 1'b0;
         bus.frame_strobe <= 1'b0;
      end else begin
         cand_r           <= '{cnt: bus.cnt_in, adr: bus.adr_in};
         fill             <= fill_nxt;
         ovf_acc          <= ovf_nxt;
         last_adr         <= last_nxt;
         slots            <= slots_nxt;
         bus.frame_strobe <= 1'b0;
         if (frame_first_c) frame_open <= 1'b1;
         if (frame_last_c && frame_open) begin
            bus.clusters     <= clusters_nxt;
            bus.n_clusters   <= fill_nxt;
            bus.overflow     <= ovf_nxt;
            bus.frame_strobe <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cluster_collector.sv
// Scoreboard bench for cluster_collector: three instances (8 slots/offset 0,
// 6 slots/offset 0, 8 slots/offset 3) share clock and reset.
module tb_cluster_collector;
   import cluster_collector_pkg::*;

   typedef struct {
      logic [111:0] clusters;
      logic [3:0]   n;
      logic         ovf;
   } exp_t;

   localparam logic [13:0]  NONE_W  = 14'h07FE;
   localparam logic [111:0] ALL8_NONE = {8{14'h07FE}};

   logic clock = 1'b0;
   logic global_reset;
   int   checks = 0;
   int   passed = 0;
   int   tb_ph  = 0;
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   always #5 clock = ~clock;

   cluster_collector_if #(.MXCLUSTERS(8)) bus0 ();
   cluster_collector_if #(.MXCLUSTERS(6)) bus1 ();
   cluster_collector_if #(.MXCLUSTERS(8)) bus2 ();

   cluster_collector #(.MXCLUSTERS(8), .PHASE_OFFSET(3'd0)) u0 (
      .clock(clock), .global_reset(global_reset), .bus(bus0));
   cluster_collector #(.MXCLUSTERS(6), .PHASE_OFFSET(3'd0)) u1 (
      .clock(clock), .global_reset(global_reset), .bus(bus1));
   cluster_collector #(.MXCLUSTERS(8), .PHASE_OFFSET(3'd3)) u2 (
      .clock(clock), .global_reset(global_reset), .bus(bus2));

   // One clock; tb_ph tracks the expected local phase of every instance.
   task automatic step();
      @(posedge clock);
      tb_ph = global_reset ? 0 : (tb_ph + 1) % 8;
      #1;
   endtask

   task automatic set_in(input int d, input logic [13:0] w);
      case (d)
         0:       begin bus0.cnt_in = w[13:11]; bus0.adr_in = w[10:0]; end
         1:       begin bus1.cnt_in = w[13:11]; bus1.adr_in = w[10:0]; end
         default: begin bus2.cnt_in = w[13:11]; bus2.adr_in = w[10:0]; end
      endcase
   endtask

   // Drives cand[f] so it is evaluated at frame slot f, and queues the
   // expected frame. Returns in the frame's last-slot cycle.
   task automatic drive_frame(input int d, input logic [13:0] cand [8]);
      int          off;
      int          mx;
      int          guard;
      int          fill;
      logic [10:0] last;
      logic [10:0] a;
      exp_t        e;
      off   = (d == 2) ? 3 : 0;
      mx    = (d == 1) ? 6 : 8;
      guard = 0;
      while (tb_ph != (off + 7) % 8 && guard < 16) begin step(); guard++; end
      if (guard >= 16) begin
         checks++;
         $display("FAIL drive_align: phase %0d never reached", (off + 7) % 8);
      end
      e.clusters = ALL8_NONE;
      e.ovf      = 1'b0;
      fill       = 0;
      last       = 11'h7FE;
      for (int f = 0; f < 8; f++) begin
         a = cand[f][10:0];
         if (a != 11'h7FE && a < 11'd1536 && a != last) begin
            if (fill < mx) begin
               e.clusters[fill*14 +: 14] = cand[f];
               fill++;
               last = a;
            end else begin
               e.ovf = 1'b1;
            end
         end
         set_in(d, cand[f]);
         step();
      end
      set_in(d, NONE_W);
      e.n = 4'(fill);
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic test_reset();
      checks++; if (bus0.clusters !== ALL8_NONE) $display("FAIL rst_clusters0: got %h exp %h", bus0.clusters, ALL8_NONE); else passed++;
      checks++; if (bus0.n_clusters !== 4'd0) $display("FAIL rst_n0: got %0d exp 0", bus0.n_clusters); else passed++;
      checks++; if (bus0.overflow !== 1'b0) $display("FAIL rst_ovf0: got %b exp 0", bus0.overflow); else passed++;
      checks++; if (bus0.frame_strobe !== 1'b0) $display("FAIL rst_strobe0: got %b exp 0", bus0.frame_strobe); else passed++;
      checks++; if (bus1.clusters !== {6{14'h07FE}}) $display("FAIL rst_clusters1: got %h", bus1.clusters); else passed++;
   endtask

   task automatic test_no_hits();
      exp_t e;
      int   cnt;
      for (int fr = 0; fr < 3; fr++) begin
         e.clusters = ALL8_NONE; e.n = 4'd0; e.ovf = 1'b0;
         q0.push_back(e);
         cnt = 0;
         do begin step(); cnt++; end while (bus0.frame_strobe !== 1'b1 && cnt < 12);
         checks++; if (cnt != 8) $display("FAIL nohit_period%0d: got %0d clocks exp 8", fr, cnt); else passed++;
         e = q0.pop_front();
         checks++; if (bus0.n_clusters !== e.n) $display("FAIL nohit_n%0d: got %0d exp %0d", fr, bus0.n_clusters, e.n); else passed++;
         checks++; if (bus0.clusters !== e.clusters) $display("FAIL nohit_clusters%0d: got %h exp %h", fr, bus0.clusters, e.clusters); else passed++;
         checks++; if (bus0.overflow !== e.ovf) $display("FAIL nohit_ovf%0d: got %b exp %b", fr, bus0.overflow, e.ovf); else passed++;
      end
   endtask

   task automatic test_hits();
      logic [13:0] c [8];
      exp_t        e;
      int          got;
      c = '{default: NONE_W};
      c[1] = {3'd2, 11'h010};
      c[4] = {3'd7, 11'h5FF};
      c[6] = {3'd0, 11'h200};
      drive_frame(0, c);
      got = 0;
      for (int i = 0; i < 4 && got == 0; i++) begin step(); got = int'(bus0.frame_strobe); end
      checks++; if (got == 0) $display("FAIL hits_strobe: got none exp pulse"); else passed++;
      e = q0.pop_front();
      checks++; if (bus0.n_clusters !== e.n) $display("FAIL hits_n: got %0d exp %0d", bus0.n_clusters, e.n); else passed++;
      checks++; if (bus0.clusters !== e.clusters) $display("FAIL hits_clusters: got %h exp %h", bus0.clusters, e.clusters); else passed++;
      checks++; if (bus0.overflow !== e.ovf) $display("FAIL hits_ovf: got %b exp %b", bus0.overflow, e.ovf); else passed++;
   endtask

   task automatic test_dup_range();
      logic [13:0] c [8];
      exp_t        e;
      int          got;
      c = '{default: NONE_W};
      for (int f = 0; f < 4; f++) c[f] = {3'd1, 11'h123};
      c[5] = {3'd3, 11'h600};
      drive_frame(0, c);
      got = 0;
      for (int i = 0; i < 4 && got == 0; i++) begin step(); got = int'(bus0.frame_strobe); end
      checks++; if (got == 0) $display("FAIL dup_strobe: got none exp pulse"); else passed++;
      e = q0.pop_front();
      checks++; if (bus0.n_clusters !== e.n) $display("FAIL dup_n: got %0d exp %0d", bus0.n_clusters, e.n); else passed++;
      checks++; if (bus0.clusters !== e.clusters) $display("FAIL dup_clusters: got %h exp %h", bus0.clusters, e.clusters); else passed++;
   endtask

   task automatic test_overflow();
      logic [13:0] c [8];
      exp_t        e;
      int          got;
      for (int f = 0; f < 8; f++) c[f] = {3'(f), 11'(f)};
      drive_frame(1, c);
      got = 0;
      for (int i = 0; i < 4 && got == 0; i++) begin step(); got = int'(bus1.frame_strobe); end
      checks++; if (got == 0) $display("FAIL ovf_strobe: got none exp pulse"); else passed++;
      e = q1.pop_front();
      checks++; if (bus1.n_clusters !== e.n) $display("FAIL ovf_n: got %0d exp %0d", bus1.n_clusters, e.n); else passed++;
      checks++; if (bus1.clusters !== e.clusters[83:0]) $display("FAIL ovf_clusters: got %h exp %h", bus1.clusters, e.clusters[83:0]); else passed++;
      checks++; if (bus1.overflow !== e.ovf) $display("FAIL ovf_flag: got %b exp %b", bus1.overflow, e.ovf); else passed++;
      c = '{default: NONE_W};
      drive_frame(1, c);
      got = 0;
      for (int i = 0; i < 4 && got == 0; i++) begin step(); got = int'(bus1.frame_strobe); end
      e = q1.pop_front();
      checks++; if (got == 0 || bus1.overflow !== e.ovf) $display("FAIL ovf_clear: strobe %0d ovf %b exp %b", got, bus1.overflow, e.ovf); else passed++;
      checks++; if (bus1.n_clusters !== e.n) $display("FAIL ovf_clear_n: got %0d exp %0d", bus1.n_clusters, e.n); else passed++;
   endtask

   task automatic test_offset();
      logic [13:0] c [8];
      exp_t        e;
      int          got;
      c = '{default: NONE_W};
      c[0] = {3'd5, 11'h0AB};
      c[3] = {3'd1, 11'h3C4};
      drive_frame(2, c);
      got = 0;
      for (int i = 0; i < 4 && got == 0; i++) begin step(); got = int'(bus2.frame_strobe); end
      checks++; if (got == 0 || tb_ph != 3) $display("FAIL off_strobe_phase: strobe %0d at phase %0d exp phase 3", got, tb_ph); else passed++;
      e = q2.pop_front();
      checks++; if (bus2.clusters !== e.clusters) $display("FAIL off_clusters: got %h exp %h", bus2.clusters, e.clusters); else passed++;
      checks++; if (bus2.n_clusters !== e.n) $display("FAIL off_n: got %0d exp %0d", bus2.n_clusters, e.n); else passed++;
   endtask

   task automatic test_mid_reset();
      logic [13:0] c [8];
      exp_t        e;
      int          got;
      int          early;
      c = '{default: NONE_W};
      c[2] = {3'd4, 11'h0F0};
      drive_frame(0, c);
      got = 0;
      for (int i = 0; i < 4 && got == 0; i++) begin step(); got = int'(bus0.frame_strobe); end
      e = q0.pop_front();
      checks++; if (got == 0 || bus0.clusters !== e.clusters) $display("FAIL mr_pre_clusters: got %h exp %h", bus0.clusters, e.clusters); else passed++;
      // partial frame: 0x001 at slot 1, 0x002 at slot 2, reset in slot 4
      set_in(0, {3'd1, 11'h001}); step();
      set_in(0, {3'd2, 11'h002}); step();
      set_in(0, NONE_W);          step();
      step();
      global_reset = 1'b1;
      step();
      checks++; if (bus0.clusters !== ALL8_NONE) $display("FAIL mr_rst_clusters: got %h exp %h", bus0.clusters, ALL8_NONE); else passed++;
      checks++; if (bus0.n_clusters !== 4'd0 || bus0.overflow !== 1'b0) $display("FAIL mr_rst_n_ovf: got %0d/%b exp 0/0", bus0.n_clusters, bus0.overflow); else passed++;
      step();
      global_reset = 1'b0;
      set_in(0, {3'd6, 11'h003});
      early = 0;
      for (int k = 1; k < 8; k++) begin
         step();
         if (k == 1) set_in(0, NONE_W);
         if (bus0.frame_strobe === 1'b1) early++;
      end
      checks++; if (early != 0) $display("FAIL mr_no_strobe: got %0d strobes exp 0", early); else passed++;
      e.clusters = ALL8_NONE;
      e.clusters[13:0] = {3'd6, 11'h003};
      e.n = 4'd1; e.ovf = 1'b0;
      q0.push_back(e);
      got = 0;
      for (int i = 0; i < 4 && got == 0; i++) begin step(); got = int'(bus0.frame_strobe); end
      checks++; if (got == 0 || tb_ph != 0) $display("FAIL mr_strobe: strobe %0d at phase %0d exp phase 0", got, tb_ph); else passed++;
      e = q0.pop_front();
      checks++; if (bus0.clusters !== e.clusters) $display("FAIL mr_clusters: got %h exp %h", bus0.clusters, e.clusters); else passed++;
      checks++; if (bus0.n_clusters !== e.n) $display("FAIL mr_n: got %0d exp %0d", bus0.n_clusters, e.n); else passed++;
   endtask

   initial begin
      global_reset = 1'b1;
      for (int d = 0; d < 3; d++) set_in(d, NONE_W);
      repeat (3) step();
      test_reset();
      global_reset = 1'b0;
      test_no_hits();
      test_hits();
      test_dup_range();
      test_overflow();
      test_offset();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
